message_pack: RTL and testbench
===============================

MESSAGE_PACK -- requirements
Module: message_pack

Interface
REQ-001 SHALL have parameter CFG_SCHEME, default 2'd0, constant value driven on cfg_scheme.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port data_in, input, 32, message word; first byte in [31:24].
REQ-005 SHALL have port data_in_valid, input, 1, data_in word valid.
REQ-006 SHALL have port data_in_ready, output, 1, word accepted when valid and ready both high at a rising edge.
REQ-007 SHALL have port data_in_last, input, 1, final word of message.
REQ-008 SHALL have port data_in_bytes, input, 2, valid bytes in final word (0 means 4); ignored when data_in_last is low.
REQ-009 SHALL have port data_out, output, 512, packed block for message_build data_in.
REQ-010 SHALL have ports data_out_valid (output, 1), data_out_ready (input, 1) and data_out_last (output, 1), block handshake and final-block flag.
REQ-011 SHALL have ports cfg_size (output, 64, message length in bits), cfg_scheme (output, 2), cfg_last (output, 1, constant 1).
REQ-012 SHALL have ports cfg_valid (output, 1) and cfg_ready (input, 1), config handshake.

Function
REQ-013 SHALL implement FSM states FILL (accepting words) and EMIT (block held on data_out).
REQ-014 SHALL place word k (k=0..15) of a block in data_out[511-32k -: 32]; unwritten words and invalid bytes SHALL be zero.
REQ-015 SHALL transition FILL->EMIT on the edge accepting word 15 or a word with data_in_last=1; data_out_valid SHALL be high the next cycle (1-cycle latency).
REQ-016 SHALL set data_out_last=1 only for the block closed by data_in_last.
REQ-017 SHALL hold data_out, data_out_last, data_out_valid stable in EMIT until data_out_ready; on handshake SHALL clear the block buffer, reset word index to 0 and return to FILL.
REQ-018 SHALL drive data_in_ready = (state==FILL) && !cfg_valid (combinational from registers only, not from data_in_valid).
REQ-019 SHALL maintain a 64-bit bit counter: +32 per non-last word, +8*bytes on last word (bytes 0 means 4); wraps modulo 2^64.
REQ-020 SHALL, on the edge accepting a last word, load cfg_size with the final count, assert cfg_valid next cycle, and clear the counter to 0.
REQ-021 SHALL hold cfg_size and cfg_valid until cfg_ready handshake; cfg_valid and data_out_valid are independent and may handshake in either order or the same cycle.
REQ-022 SHALL produce exactly one cfg transfer and ceil(words/16) blocks per message; a 16-word last message SHALL yield one block with data_out_last=1.

Reset
REQ-023 SHALL, while rst high, force state FILL, word index 0, block buffer 0, counter 0, data_out_valid 0, data_out_last 0, cfg_valid 0, cfg_size 0, data_in_ready 0 output effect via cfg_valid/state as per REQ-018 (ready=1 after reset release).
REQ-024 SHALL discard any partial block, pending block or pending cfg on reset mid-message; no output handshake SHALL occur in the cycle reset deasserts.

Configuration
REQ-025 SHALL, when MESSAGE_PACK_LITTLE_ENDIAN_EN is defined, byte-swap each accepted word before placement (data_in[7:0] becomes first byte) with valid bytes counted from [7:0]; without it, big-endian per REQ-004/REQ-014; counter behaviour identical in both.

Verification
REQ-026 SHALL verify: one word 0x61626300, last, bytes=3 -> one block 0x616263 followed by 488 zero bits, last=1; cfg_size=24, cfg_scheme=0, cfg_last=1.
REQ-027 SHALL verify: 20 words 0x00000001..0x00000014, last on word 20, bytes=0 -> block0 words 1..16 last=0, block1 words 17..20 then zeros last=1; cfg_size=640.
REQ-028 SHALL verify: data_out_ready held low 10 cycles after block ready -> data_out stable, data_in_ready=0 throughout, no word lost when ready rises.
REQ-029 SHALL verify: cfg_ready held low while second message starts -> data_in_ready=0 until cfg handshake, second message cfg_size independent of first.
REQ-030 SHALL verify: rst pulsed after 5 words accepted -> all valids 0, then a fresh 1-word message bytes=4 gives cfg_size=32.
REQ-031 SHALL verify with MESSAGE_PACK_LITTLE_ENDIAN_EN: word 0x00636261, last, bytes=3 -> data_out[511:488]=0x616263, cfg_size=24.

Source files
------------

// File: rtl/message_pack.sv
// Packs a stream of 32-bit message words into 512-bit blocks (16 words) and reports the message length in bits.
// Latency: a block shows on data_out one cycle after the edge that accepts its 16th word or its last word.
// Backpressure: input stalls while a block waits for data_out_ready or a length report waits for cfg_ready.
//
// Ports:
//   clk, rst                          clock; asynchronous active-high reset
//   data_in/_valid/_ready/_last/_bytes message word stream (first byte in [31:24]); _bytes = valid bytes of last word, 0 means 4
//   data_out/_valid/_ready/_last      packed block, word k in data_out[511-32k -: 32]; _last marks the block closing a message
//   cfg_size/_scheme/_last/_valid/_ready message length in bits, fixed scheme id, constant last flag, handshake
//
// Optional build macro MESSAGE_PACK_LITTLE_ENDIAN_EN: byte-swap each word on entry so data_in[7:0] is the first byte.
module message_pack #(
  parameter logic [1:0] CFG_SCHEME = 2'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  data_in,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  input  logic         data_in_last,
  input  logic [1:0]   data_in_bytes,
  output logic [511:0] data_out,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic         data_out_last,
  output logic [63:0]  cfg_size,
  output logic [1:0]   cfg_scheme,
  output logic         cfg_last,
  output logic         cfg_valid,
  input  logic         cfg_ready
);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [31:0] r_words [16];
  logic        r_last;
  logic [63:0] r_cnt;
  logic [63:0] r_cfg_size;
  logic        r_cfg_vld;

  logic        w_in_rdy;
  logic        w_out_vld;
  logic        w_acc;
  logic        w_close;
  logic        w_out_hs;
  logic        w_cfg_hs;
  logic [31:0] w_word_ord;
  logic [31:0] w_word;
  logic [63:0] w_cnt_add;
  logic [63:0] w_cnt_sum;

`ifdef MESSAGE_PACK_LITTLE_ENDIAN_EN
  assign w_word_ord = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
`else
  assign w_word_ord = data_in;
`endif

  // Zero the unused tail bytes of a last word and size its contribution to the bit count.
  always_comb begin
    w_word    = w_word_ord;
    w_cnt_add = 64'd32;
    if (data_in_last) begin
      case (data_in_bytes)
        2'd1: begin
          w_word    = {w_word_ord[31:24], 24'd0};
          w_cnt_add = 64'd8;
        end
        2'd2: begin
          w_word    = {w_word_ord[31:16], 16'd0};
          w_cnt_add = 64'd16;
        end
        2'd3: begin
          w_word    = {w_word_ord[31:8], 8'd0};
          w_cnt_add = 64'd24;
        end
        default: begin
          w_word    = w_word_ord;
          w_cnt_add = 64'd32;
        end
      endcase
    end
  end

  assign w_cnt_sum = r_cnt + w_cnt_add;

  // Next state and handshake outputs. Input readiness depends only on registers.
  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    w_out_vld   = 1'b0;
    case (r_state)
      FILL: begin
        w_in_rdy = !r_cfg_vld;
        if (data_in_valid && !r_cfg_vld && ((r_idx == 4'd15) || data_in_last)) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        w_out_vld = 1'b1;
        if (data_out_ready) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  assign w_acc    = data_in_valid && w_in_rdy;
  assign w_close  = w_acc && ((r_idx == 4'd15) || data_in_last);
  assign w_out_hs = w_out_vld && data_out_ready;
  assign w_cfg_hs = r_cfg_vld && cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Acceptance only happens in FILL and block release only in EMIT, so the two
  // branches below never touch the buffer in the same cycle. A new last word
  // cannot arrive while a length report is pending, so cfg set/clear never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= 4'd0;
      r_last     <= 1'b0;
      r_cnt      <= 64'd0;
      r_cfg_size <= 64'd0;
      r_cfg_vld  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        r_words[k] <= 32'd0;
      end
    end else begin
      if (w_acc) begin
        r_words[r_idx] <= w_word;
        r_idx          <= r_idx + 4'd1;
        if (data_in_last) begin
          r_cnt      <= 64'd0;
          r_cfg_size <= w_cnt_sum;
          r_cfg_vld  <= 1'b1;
        end else begin
          r_cnt <= w_cnt_sum;
        end
        if (w_close) begin
          r_last <= data_in_last;
        end
      end
      if (w_out_hs) begin
        r_idx  <= 4'd0;
        r_last <= 1'b0;
        for (int k = 0; k < 16; k++) begin
          r_words[k] <= 32'd0;
        end
      end
      if (w_cfg_hs) begin
        r_cfg_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < 16; k++) begin
      data_out[511-32*k -: 32] = r_words[k];
    end
  end

  assign data_in_ready  = w_in_rdy;
  assign data_out_valid = w_out_vld;
  assign data_out_last  = r_last;
  assign cfg_size       = r_cfg_size;
  assign cfg_scheme     = CFG_SCHEME;
  assign cfg_last       = 1'b1;
  assign cfg_valid      = r_cfg_vld;

endmodule

// File: tb/tb_message_pack.sv
module tb_message_pack;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic         data_in_last;
  logic [1:0]   data_in_bytes;
  logic [511:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready;
  logic         data_out_last;
  logic [63:0]  cfg_size;
  logic [1:0]   cfg_scheme;
  logic         cfg_last;
  logic         cfg_valid;
  logic         cfg_ready;

  message_pack dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_in_last  (data_in_last),
    .data_in_bytes (data_in_bytes),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_last (data_out_last),
    .cfg_size      (cfg_size),
    .cfg_scheme    (cfg_scheme),
    .cfg_last      (cfg_last),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs, queued in order of appearance.
  logic [511:0] exp_blk_q [$];
  logic         exp_last_q[$];
  logic [63:0]  exp_cfg_q [$];

  // Most recent values actually handed over by the DUT.
  logic [511:0] got_blk;
  logic         got_blk_last;
  logic [63:0]  got_cfg;

  logic [31:0]  wq[$];
  logic [511:0] lit;
  logic [511:0] held;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Message-level model: split words into groups of 16, zero unused bytes of the
  // last word, and report 32 bits per full word plus 8 per valid byte of the last.
  task automatic model_msg(input logic [31:0] w[$], input logic [1:0] nb);
    int           n;
    int           nbytes;
    logic [511:0] blk;
    logic [31:0]  x;
    logic [31:0]  ones;
    n      = w.size();
    nbytes = (nb == 2'd0) ? 4 : int'(nb);
    blk    = '0;
    ones   = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      x = w[i];
`ifdef MESSAGE_PACK_LITTLE_ENDIAN_EN
      x = {x[7:0], x[15:8], x[23:16], x[31:24]};
`endif
      if (i == n - 1) x = x & ~(ones >> (8 * nbytes));
      blk[511 - 32 * (i % 16) -: 32] = x;
      if ((i % 16 == 15) || (i == n - 1)) begin
        exp_blk_q.push_back(blk);
        exp_last_q.push_back(i == n - 1);
        blk = '0;
      end
    end
    exp_cfg_q.push_back(64'(32 * (n - 1) + 8 * nbytes));
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!data_in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!data_in_ready) fail_now("in_ready_wait");
  endtask

  // Drives the words back to back; checks that a closing word shows its block next cycle.
  task automatic send(input logic [31:0] w[$], input logic [1:0] nb, input bit is_last);
    bit lw;
    for (int i = 0; i < w.size(); i++) begin
      lw            = is_last && (i == w.size() - 1);
      data_in       = w[i];
      data_in_valid = 1'b1;
      data_in_last  = lw;
      data_in_bytes = lw ? nb : 2'd1;  // ignored on non-last words
      wait_ready();
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
      if (lw || (i % 16 == 15)) begin
        @(negedge clk);
        chk("out_latency", data_out_valid, 1'b1);
        if (lw) chk("cfg_latency", cfg_valid, 1'b1);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_blk_q.size() != 0 || exp_cfg_q.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_blk_q.size() != 0 || exp_cfg_q.size() != 0) begin
      fail_now("drain");
      exp_blk_q.delete();
      exp_last_q.delete();
      exp_cfg_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle out of reset, check whatever the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_rule", data_in_ready, !data_out_valid && !cfg_valid);
      if (data_out_valid) begin
        if (exp_blk_q.size() == 0) begin
          fail_now("unexpected_block");
        end else begin
          chk("data_out", data_out, exp_blk_q[0]);
          chk("data_out_last", data_out_last, exp_last_q[0]);
          if (data_out_ready) begin
            got_blk      = data_out;
            got_blk_last = data_out_last;
            void'(exp_blk_q.pop_front());
            void'(exp_last_q.pop_front());
          end
        end
      end
      if (cfg_valid) begin
        if (exp_cfg_q.size() == 0) begin
          fail_now("unexpected_cfg");
        end else begin
          chk("cfg_size", cfg_size, exp_cfg_q[0]);
          chk("cfg_scheme", cfg_scheme, 2'd0);
          chk("cfg_last", cfg_last, 1'b1);
          if (cfg_ready) begin
            got_cfg = cfg_size;
            void'(exp_cfg_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_in_last   = 1'b0;
    data_in_bytes  = 2'd0;
    data_out_ready = 1'b1;
    cfg_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", data_out_valid, 1'b0);
    chk("rst_out_last", data_out_last, 1'b0);
    chk("rst_cfg_valid", cfg_valid, 1'b0);
    chk("rst_cfg_size", cfg_size, 64'd0);
    chk("rst_data_out", data_out, 512'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", data_in_ready, 1'b1);
    @(posedge clk);
    #1;

`ifdef MESSAGE_PACK_LITTLE_ENDIAN_EN
    // Little-endian: 0x00636261, 3 bytes.
    wq  = '{32'h0063_6261};
    lit = {24'h616263, 488'd0};
    model_msg(wq, 2'd3);
    chk("model_le_blk", exp_blk_q[0], lit);
    send(wq, 2'd3, 1'b1);
    drain();
    chk("le_blk", got_blk, lit);
    chk("le_cfg", got_cfg, 64'd24);
`else
    // One word, 3 valid bytes.
    wq  = '{32'h6162_6300};
    lit = {24'h616263, 488'd0};
    model_msg(wq, 2'd3);
    chk("model_t1_blk", exp_blk_q[0], lit);
    chk("model_t1_cfg", exp_cfg_q[0], 64'd24);
    send(wq, 2'd3, 1'b1);
    drain();
    chk("t1_blk", got_blk, lit);
    chk("t1_last", got_blk_last, 1'b1);
    chk("t1_cfg", got_cfg, 64'd24);
`endif

    // 20 words 1..20 -> two blocks, 640 bits.
    wq.delete();
    for (int i = 1; i <= 20; i++) wq.push_back(32'(i));
    lit = {32'd17, 32'd18, 32'd19, 32'd20, 384'd0};
    model_msg(wq, 2'd0);
    chk("model_t2_blk1", exp_blk_q[1], lit);
    chk("model_t2_cfg", exp_cfg_q[0], 64'd640);
    send(wq, 2'd0, 1'b1);
    drain();
    chk("t2_blk1", got_blk, lit);
    chk("t2_cfg", got_cfg, 64'd640);

    // Block held with data_out_ready low for 10 cycles; 17th word must survive.
    wq.delete();
    for (int i = 0; i < 17; i++) wq.push_back(32'hA000_0000 + 32'(i));
    model_msg(wq, 2'd2);
    data_out_ready = 1'b0;
    fork
      send(wq, 2'd2, 1'b1);
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!data_out_valid && t < 300) begin
          @(negedge clk);
          t++;
        end
        if (!data_out_valid) fail_now("t3_wait_block");
        held = data_out;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("t3_hold_in_ready", data_in_ready, 1'b0);
          chk("t3_hold_data", data_out, held);
          chk("t3_hold_valid", data_out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
      end
    join
    drain();
    chk("t3_cfg", got_cfg, 64'd528);
    chk("t3_last", got_blk_last, 1'b1);

    // Length report stalled while the next message waits.
    cfg_ready = 1'b0;
    wq = '{32'hA1A1_A1A1, 32'hA2A2_0000};
    model_msg(wq, 2'd2);
    send(wq, 2'd2, 1'b1);
    wq = '{32'hBB00_0000};
    model_msg(wq, 2'd1);
    fork
      send(wq, 2'd1, 1'b1);
      begin
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          chk("t4_in_ready_blocked", data_in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        cfg_ready = 1'b1;
      end
    join
    drain();
    chk("t4_cfg_second", got_cfg, 64'd8);

    // Reset after 5 accepted words of an unfinished message.
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(32'hC0DE_0000 + 32'(i));
    send(wq, 2'd0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", data_out_valid, 1'b0);
    chk("t5_rst_cfg_valid", cfg_valid, 1'b0);
    chk("t5_rst_cfg_size", cfg_size, 64'd0);
    chk("t5_rst_data_out", data_out, 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq = '{32'h1234_5678};
    lit = {32'h1234_5678, 480'd0};
    model_msg(wq, 2'd0);
    send(wq, 2'd0, 1'b1);
    drain();
    chk("t5_cfg", got_cfg, 64'd32);
    chk("t5_blk", got_blk, lit);

    // Exactly 16 words with last -> single final block.
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(32'h5500_0000 | 32'(i * 7));
    model_msg(wq, 2'd1);
    chk("model_t6_nblk", exp_blk_q.size(), 1);
    send(wq, 2'd1, 1'b1);
    drain();
    chk("t6_last", got_blk_last, 1'b1);
    chk("t6_cfg", got_cfg, 64'd488);

    // 32 pseudo-random words -> two blocks.
    wq.delete();
    for (int i = 0; i < 32; i++) wq.push_back($urandom);
    model_msg(wq, 2'd3);
    send(wq, 2'd3, 1'b1);
    drain();
    chk("t7_cfg", got_cfg, 64'd1016);
    chk("t7_last", got_blk_last, 1'b1);

    chk("leftover_blocks", exp_blk_q.size(), 0);
    chk("leftover_cfg", exp_cfg_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
